// File: rtl/mixer_pkg.sv
// Shared definitions for the audio mixer family: FSM encoding, width helpers
// and a generic saturating clamp reusable by other audio blocks.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mix_state_t;

  // Gain code 2^(gain_w-1) is unity, so products are rescaled by this shift.
  function automatic int gain_unity_shift(input int gain_w);
    return gain_w - 1;
  endfunction

  function automatic int acc_width(input int data_w, input int gain_w, input int num_ch);
    return data_w + gain_w + $clog2(num_ch) + 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/stereo_mixer_ramped_gain_ramp.sv
// Current-gain register that steps one code toward its target per enable and
// holds once it arrives, so a gain change never produces a click.
module gain_ramp #(
  parameter int GAIN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic [GAIN_W-1:0] target,
  output logic [GAIN_W-1:0] gain
);

  always_ff @(posedge clk) begin
    if (rst) begin
      gain <= '0;
    end else if (step_en) begin
      if (gain < target)      gain <= gain + 1'b1;
      else if (gain > target) gain <= gain - 1'b1;
    end
  end

endmodule

// File: rtl/stereo_mixer_ramped.sv
// N-channel stereo mixer with ramped per-channel gains, one shared MAC stepping
// through the channels, and saturating registered outputs.
//
// state  | meaning
// IDLE   | waiting for sample_valid; accepting captures samples and steps gains
// ACCUM  | one channel per cycle into acc_l/acc_r; last channel loads outputs
// OUTPUT | out_valid pulse with the freshly registered mix
module stereo_mixer_ramped
  import mixer_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NUM_CH*DATA_W-1:0]   sample_in,
  input  logic [NUM_CH*GAIN_W-1:0]   gain_l_target,
  input  logic [NUM_CH*GAIN_W-1:0]   gain_r_target,
  input  logic                       stereo_on,
  output logic signed [DATA_W-1:0]   sample_l,
  output logic signed [DATA_W-1:0]   sample_r,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W  = acc_width(DATA_W, GAIN_W, NUM_CH);
  localparam int SHIFT  = gain_unity_shift(GAIN_W);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << SHIFT);

  mix_state_t state, state_next;

  logic [NUM_CH*DATA_W-1:0] sample_cap;
  logic                     stereo_cap;
  logic [IDX_W-1:0]         ch_idx;
  logic signed [ACC_W-1:0]  acc_l, acc_r, acc_l_sum, acc_r_sum;
  logic signed [PROD_W-1:0] prod_l, prod_r;
  logic signed [DATA_W-1:0] s_cur;
  logic [GAIN_W-1:0]        g_l_eff, g_r_eff;
  logic [GAIN_W-1:0]        gain_l [NUM_CH];
  logic [GAIN_W-1:0]        gain_r [NUM_CH];
  logic                     accept;

  // Ramps step on acceptance so the ACCUM pass already sees the new gains.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ramp
    gain_ramp #(.GAIN_W(GAIN_W)) u_ramp_l (
      .clk(clk), .rst(rst), .step_en(accept),
      .target(gain_l_target[i*GAIN_W +: GAIN_W]), .gain(gain_l[i])
    );
    gain_ramp #(.GAIN_W(GAIN_W)) u_ramp_r (
      .clk(clk), .rst(rst), .step_en(accept),
      .target(gain_r_target[i*GAIN_W +: GAIN_W]), .gain(gain_r[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid) state_next = ACCUM;
      ACCUM:   if (ch_idx == LAST_IDX) state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && sample_valid;
    busy      = (state != IDLE);
    out_valid = (state == OUTPUT);
  end

  // Mono mode substitutes the unity code, which equals s <<< SHIFT.
  always_comb begin
    s_cur     = sample_cap[ch_idx*DATA_W +: DATA_W];
    g_l_eff   = stereo_cap ? gain_l[ch_idx] : UNITY;
    g_r_eff   = stereo_cap ? gain_r[ch_idx] : UNITY;
    prod_l    = PROD_W'(s_cur) * $signed({1'b0, g_l_eff});
    prod_r    = PROD_W'(s_cur) * $signed({1'b0, g_r_eff});
    acc_l_sum = acc_l + ACC_W'(prod_l);
    acc_r_sum = acc_r + ACC_W'(prod_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cap <= '0;
      stereo_cap <= 1'b0;
      ch_idx     <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      sample_l   <= '0;
      sample_r   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        sample_cap <= sample_in;
        stereo_cap <= stereo_on;
      end
      if (state == IDLE) begin
        ch_idx <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
      end else if (state == ACCUM) begin
        ch_idx <= ch_idx + 1'b1;
        acc_l  <= acc_l_sum;
        acc_r  <= acc_r_sum;
        // Load outputs on the final channel so they are stable during OUTPUT.
        if (ch_idx == LAST_IDX) begin
          sample_l <= DATA_W'(saturate(64'(acc_l_sum >>> SHIFT), DATA_W));
          sample_r <= DATA_W'(saturate(64'(acc_r_sum >>> SHIFT), DATA_W));
        end
      end
      if (sample_valid && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stereo_mixer_ramped.sv
// Directed scoreboard bench for stereo_mixer_ramped (NUM_CH=3, DATA_W=16, GAIN_W=4).
module tb_stereo_mixer_ramped;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int GAIN_W = 4;

  logic clk = 1'b0;
  logic rst, sample_valid, stereo_on;
  logic [NUM_CH*DATA_W-1:0] sample_in;
  logic [NUM_CH*GAIN_W-1:0] gain_l_target, gain_r_target;
  logic signed [DATA_W-1:0] sample_l, sample_r;
  logic out_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;
  int exp_l_q[$];
  int exp_r_q[$];

  always #5 clk = ~clk;

  stereo_mixer_ramped #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .gain_l_target(gain_l_target), .gain_r_target(gain_r_target),
    .stereo_on(stereo_on), .sample_l(sample_l), .sample_r(sample_r),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every out_valid pops one expected pair.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_l_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=%0d/%0d required=no_output", sample_l, sample_r);
      end else begin
        int el, er;
        el = exp_l_q.pop_front();
        er = exp_r_q.pop_front();
        check("mix_l", sample_l, el);
        check("mix_r", sample_r, er);
      end
    end
  end

  // One accepted strobe with out_valid expected exactly 4 cycles later; 10-cycle spacing.
  task automatic strobe(input int s0, input int s1, input int s2, input int el, input int er);
    sample_in    = {16'(s2), 16'(s1), 16'(s0)};
    sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    exp_l_q.push_back(el);
    exp_r_q.push_back(er);
    repeat (2) @(posedge clk);
    #1 check("latency_early", out_valid, 0);
    @(posedge clk);
    #1 check("latency_on_time", out_valid, 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    sample_valid  = 1'b0;
    stereo_on     = 1'b1;
    sample_in     = '0;
    gain_l_target = {3{4'd8}};
    gain_r_target = {3{4'd8}};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_sample_l", sample_l, 0);
    check("reset_sample_r", sample_r, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);

    // Ramp from gain 0 toward unity: 750 per step, settling at 6000.
    for (int k = 1; k <= 9; k++)
      strobe(1000, 2000, 3000, 750 * ((k < 8) ? k : 8), 750 * ((k < 8) ? k : 8));

    // Ramp 8 -> 15 with silent samples, then saturate both ways.
    gain_l_target = {3{4'd15}};
    gain_r_target = {3{4'd15}};
    for (int k = 0; k < 7; k++) strobe(0, 0, 0, 0, 0);
    strobe(30000, 30000, 30000, 32767, 32767);
    strobe(-30000, -30000, -30000, -32768, -32768);

    // Hard pan ch0 left: R ch0 needs 15 steps to reach 0.
    gain_l_target = {3{4'd8}};
    gain_r_target = {4'd8, 4'd8, 4'd0};
    for (int k = 0; k < 15; k++) strobe(0, 0, 0, 0, 0);
    strobe(1000, 2000, 3000, 6000, 5000);
    check("overrun_before", overrun, 0);

    // Overrun: second strobe two cycles after the first is dropped.
    sample_in    = {16'd3000, 16'd2000, 16'd1000};
    sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    exp_l_q.push_back(6000);
    exp_r_q.push_back(5000);
    @(posedge clk);
    #1 sample_in = {3{16'd5000}};
    sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("overrun_set", overrun, 1);
    check("busy_after_overrun", busy, 0);
    strobe(1000, 2000, 3000, 6000, 5000);
    check("overrun_sticky", overrun, 1);

    // Reset two cycles into a mix: aborted, no output, everything cleared.
    sample_in    = {16'd3000, 16'd2000, 16'd1000};
    sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid_sample_l", sample_l, 0);
    check("rst_mid_sample_r", sample_r, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", overrun, 0);
    repeat (6) @(posedge clk);
    #1;

    // Mono unity mix with all gains 0, then ramp restarts from gain 0.
    stereo_on     = 1'b0;
    gain_l_target = '0;
    gain_r_target = '0;
    strobe(100, -300, 50, -150, -150);
    stereo_on     = 1'b1;
    gain_l_target = {3{4'd8}};
    gain_r_target = {3{4'd8}};
    strobe(1000, 2000, 3000, 750, 750);

    for (int i = 0; i < 20 && exp_l_q.size() != 0; i++) @(posedge clk);
    #1 check("scoreboard_drained", exp_l_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stereo_mixer_ramped.md
Name: stereo_mixer_ramped

Overview:
- Parametrised N-channel stereo mixer, successor to the fixed 3-channel, 2-bit-pan conditioner.
- Per-channel left/right gain with click-free ramping: current gain steps toward target by 1 code per accepted sample.
- Single time-multiplexed multiply-accumulate datapath with saturating output and valid handshake.
- Sits between the per-voice note generators and the audio output/PWM stage.

Parameters:
- NUM_CH, 3, number of input voices (>=1).
- DATA_W, 16, signed sample width.
- GAIN_W, 4, gain code width. Gain = code / 2^(GAIN_W-1). Code 8 = unity, 15 = 1.875x.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  one-cycle strobe; sample_in valid this cycle
- sample_in  in  NUM_CH*DATA_W  signed samples; ch i at bits [i*DATA_W +: DATA_W]
- gain_l_target  in  NUM_CH*GAIN_W  unsigned left target gain per channel
- gain_r_target  in  NUM_CH*GAIN_W  unsigned right target gain per channel
- stereo_on  in  1  1 = use gains; 0 = mono unity mix on both sides
- sample_l  out  DATA_W  signed left mix, registered
- sample_r  out  DATA_W  signed right mix, registered
- out_valid  out  1  one-cycle pulse when sample_l/sample_r update
- busy  out  1  high while a mix is in progress
- overrun  out  1  sticky; set when sample_valid arrives while busy

Behaviour:
- Clock is clk only. rst is synchronous and active-high.
- Reset values: sample_l=0, sample_r=0, out_valid=0, busy=0, overrun=0. All current gains 0, accumulators 0, FSM in IDLE.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE, on sample_valid: capture sample_in, gain targets and stereo_on into registers.
  - Step every current gain ±1 toward its target; hold if equal.
  - Clear accumulators, set ch_idx=0, go to ACCUM, busy=1.
- ACCUM: one channel per cycle, using the updated gains.
  - acc_l += s*g_l and acc_r += s*g_r.
  - When captured stereo_on=0: acc_l += s<<(GAIN_W-1) and acc_r += the same (unity). Current gains still ramp in this mode.
  - After ch_idx=NUM_CH-1, go to OUTPUT.
- OUTPUT:
  - Arithmetic right shift of each accumulator by GAIN_W-1 (floor toward -inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register into sample_l/sample_r.
  - out_valid=1 for this cycle only, then go to IDLE with busy=0.
- Latency: the strobe in cycle T produces out_valid in cycle T+NUM_CH+1. Minimum sample spacing is NUM_CH+2 cycles.
- Accumulator width: DATA_W+GAIN_W+clog2(NUM_CH)+1 signed. No intermediate overflow is permitted.
- sample_valid while busy (including during the OUTPUT cycle): strobe ignored, overrun set. The in-flight mix and the gains are unaffected. overrun clears only on rst.
- sample_valid in the same cycle FSM returns to IDLE: accepted normally.
- Target changes mid-mix have no effect until the next accepted strobe, because targets are captured at acceptance.
- rst mid-ACCUM: mix aborted, no out_valid, all state returns to reset values; outputs 0 next cycle.
- Gain ramp saturates at its target; no wrap.

Decomposition:
- Shared package mixer_pkg holds:
  - FSM state enum.
  - GAIN_UNITY_SHIFT = GAIN_W-1.
  - Accumulator-width function.
  - Saturate function for reuse by other audio blocks.
- One natural sub-module, gain_ramp: a per-channel current-gain register with a step-toward-target enable, instantiated 2*NUM_CH times.

Test Plan (NUM_CH=3, DATA_W=16, GAIN_W=4):
- Ramp: after rst, all targets L=R=8, samples 1000/2000/3000 strobed every 10 cycles.
  - 1st output L=R=750 at T+4.
  - Outputs increase by 750 per strobe; 8th and later outputs = 6000.
- Saturation: all gains settled at 15, samples 30000 each -> sample_l=sample_r=32767. Samples -30000 each -> -32768.
- Hard pan: ch0 L=8 R=0, ch1/ch2 L=R=8, settled, samples 1000/2000/3000 -> sample_l=6000, sample_r=5000.
- Mono: stereo_on=0, gains all 0, samples 100/-300/50 -> sample_l=sample_r=-150 on the first strobe after reset.
- Overrun: second strobe 2 cycles after the first -> overrun=1, exactly one out_valid, first result correct, next valid strobe accepted.
- Reset mid-op: assert rst at T+2 of a mix -> no out_valid; sample_l=sample_r=0, busy=0, overrun=0; next mix restarts the ramp from gain 0.
